cache_cmd_sequencer: RTL and testbench



---
 rtl/cache_cmd_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_cache_cmd_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cache_cmd_sequencer.sv
// rtl/cache_cmd_sequencer.sv - one-command-at-a-time sequencer between register block and cache core
//
// Purpose:
//   Watches CTRL.operation in the register block. A non-NOOP value is latched
//   together with KEY/DAT and presented to the cache core as a valid/ready request.
//   The core response (or a timeout) is written back as hit/data/busy. The same
//   write-back returns CTRL.operation to NOOP.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   reg_rd_i             packed reg_read_t: current DAT/KEY/CTRL.operation
//   reg_wr_o             packed reg_write_t: write-back fields plus per-field valid strobes
//   core_req_valid_o     request valid to cache core
//   core_req_ready_i     core accepts request
//   core_op_o            latched operation
//   core_key_o           latched key
//   core_value_o         latched data (WRITE payload)
//   core_resp_valid_i    single-cycle response strobe
//   core_resp_hit_i      key found/updated
//   core_resp_value_i    read value, qualified by core_resp_valid_i
//   timeout_o            one-cycle pulse in the DONE cycle of a timed-out command
//   idle_o               sequencer is in IDLE

package if_types_pkg;
  localparam int RegKeyWidth  = 16;
  localparam int RegDataWidth = 32;

  typedef enum logic [2:0] {
    OP_NOOP   = 3'd0,
    OP_READ   = 3'd1,
    OP_WRITE  = 3'd2,
    OP_DELETE = 3'd3
  } operation_e;

  typedef struct packed {
    logic [RegDataWidth-1:0] dat;
    logic [RegKeyWidth-1:0]  key;
    operation_e              operation;
  } reg_read_t;

  typedef struct packed {
    logic [RegDataWidth-1:0] dat;
    logic                    data_valid;
    logic                    hit;
    logic                    hit_valid;
    logic                    busy;
    logic                    busy_valid;
    operation_e              operation;
    logic                    operation_valid;
  } reg_write_t;
endpackage

module cache_cmd_sequencer
  import if_types_pkg::*;
#(
  parameter int TimeoutCycles = 1024,
  parameter int CntWidth      = $clog2(TimeoutCycles + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [$bits(reg_read_t)-1:0]  reg_rd_i,
  output logic [$bits(reg_write_t)-1:0] reg_wr_o,
  output logic                          core_req_valid_o,
  input  logic                          core_req_ready_i,
  output logic [2:0]                    core_op_o,
  output logic [RegKeyWidth-1:0]        core_key_o,
  output logic [RegDataWidth-1:0]       core_value_o,
  input  logic                          core_resp_valid_i,
  input  logic                          core_resp_hit_i,
  input  logic [RegDataWidth-1:0]       core_resp_value_i,
  output logic                          timeout_o,
  output logic                          idle_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  reg_read_t rd;
  assign rd = reg_rd_i;

  state_e                  state_q, state_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [2:0]              op_q, op_d;
  logic [RegKeyWidth-1:0]  key_q, key_d;
  logic [RegDataWidth-1:0] val_q, val_d;
  logic                    unsup_q, unsup_d;
  logic                    hit_q, hit_d;
  logic [RegDataWidth-1:0] rdata_q, rdata_d;
  reg_write_t              wb_q, wb_d;
  logic                    req_valid_q, req_valid_d;
  logic                    timeout_q, timeout_d;
  logic                    timed_out;
  logic                    handshake;

  assign handshake = req_valid_q && core_req_ready_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    key_d       = key_q;
    val_d       = val_q;
    unsup_d     = unsup_q;
    hit_d       = hit_q;
    rdata_d     = rdata_q;
    wb_d        = '0;
    timed_out   = 1'b0;
    req_valid_d = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rd.operation != OP_NOOP) begin
          op_d            = rd.operation;
          key_d           = rd.key;
          val_d           = rd.dat;
          unsup_d         = (rd.operation > OP_DELETE);
          hit_d           = 1'b0;
          rdata_d         = '0;
          cnt_d           = '0;
          // Unsupported ops also pass through ISSUE for one cycle, with the
          // request held low. This keeps the busy=1 pulse and the DONE
          // write-back (busy=0) in separate cycles.
          state_d         = S_ISSUE;
          wb_d.busy       = 1'b1;
          wb_d.busy_valid = 1'b1;
        end
      end

      S_ISSUE: begin
        if (unsup_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
          if (handshake && core_resp_valid_i) begin
            hit_d   = core_resp_hit_i;
            rdata_d = core_resp_value_i;
            state_d = S_DONE;
          end else if (cnt_q == CntLast) begin
            timed_out = 1'b1;
            state_d   = S_DONE;
          end else if (handshake) begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CntWidth'(1);
        if (core_resp_valid_i) begin
          hit_d   = core_resp_hit_i;
          rdata_d = core_resp_value_i;
          state_d = S_DONE;
        end else if (cnt_q == CntLast) begin
          timed_out = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The write-back is registered on the edge entering DONE, so it is
    // visible for exactly the one DONE cycle. The register block applies it at
    // the edge that ends DONE, so IDLE sees operation=NOOP and cannot retrigger.
    if (state_d == S_DONE) begin
      wb_d.busy            = 1'b0;
      wb_d.busy_valid      = 1'b1;
      wb_d.operation       = OP_NOOP;
      wb_d.operation_valid = 1'b1;
      wb_d.hit             = hit_d;
      wb_d.hit_valid       = 1'b1;
      if ((op_d == 3'(OP_READ)) && hit_d) begin
        wb_d.dat        = rdata_d;
        wb_d.data_valid = 1'b1;
      end
      timeout_d = timed_out;
    end

    req_valid_d = (state_d == S_ISSUE) && !unsup_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      key_q       <= '0;
      val_q       <= '0;
      unsup_q     <= 1'b0;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
      wb_q        <= '0;
      req_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      key_q       <= key_d;
      val_q       <= val_d;
      unsup_q     <= unsup_d;
      hit_q       <= hit_d;
      rdata_q     <= rdata_d;
      wb_q        <= wb_d;
      req_valid_q <= req_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign reg_wr_o         = wb_q;
  assign core_req_valid_o = req_valid_q;
  assign core_op_o        = op_q;
  assign core_key_o       = key_q;
  assign core_value_o     = val_q;
  assign timeout_o        = timeout_q;
  assign idle_o           = (state_q == S_IDLE);

endmodule

// File: tb/tb_cache_cmd_sequencer.sv
// tb/tb_cache_cmd_sequencer.sv - directed self-checking bench for cache_cmd_sequencer
module tb_cache_cmd_sequencer;
  import if_types_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  reg_read_t rd;
  reg_write_t wr;
  logic [$bits(reg_write_t)-1:0] reg_wr;
  logic req_valid, req_ready;
  logic [2:0] core_op;
  logic [RegKeyWidth-1:0] core_key;
  logic [RegDataWidth-1:0] core_value;
  logic resp_valid, resp_hit;
  logic [RegDataWidth-1:0] resp_value;
  logic timeout, idle;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign wr = reg_wr;

  cache_cmd_sequencer #(.TimeoutCycles(16)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .reg_rd_i         (rd),
    .reg_wr_o         (reg_wr),
    .core_req_valid_o (req_valid),
    .core_req_ready_i (req_ready),
    .core_op_o        (core_op),
    .core_key_o       (core_key),
    .core_value_o     (core_value),
    .core_resp_valid_i(resp_valid),
    .core_resp_hit_i  (resp_hit),
    .core_resp_value_i(resp_value),
    .timeout_o        (timeout),
    .idle_o           (idle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected DONE write-back: {busy, busy_valid, op, op_valid, hit_valid, hit, data_valid}
  task automatic chk_done(input string tag, input logic hit, input logic dv,
                          input logic [RegDataWidth-1:0] dat, input logic tmo);
    chk({tag, "_ctrl"}, {wr.busy, wr.busy_valid, 3'(wr.operation), wr.operation_valid,
                         wr.hit_valid, wr.hit, wr.data_valid},
        {1'b0, 1'b1, 3'd0, 1'b1, 1'b1, hit, dv});
    if (dv) chk({tag, "_dat"}, wr.dat, dat);
    chk({tag, "_tmo"}, timeout, tmo);
    chk({tag, "_req"}, req_valid, 1'b0);
    chk({tag, "_idle"}, idle, 1'b0);
  endtask

  task automatic chk_busy(input string tag, input logic exp_req);
    chk({tag, "_busy"}, {wr.busy, wr.busy_valid, wr.operation_valid, wr.hit_valid, wr.data_valid},
        5'b11000);
    chk({tag, "_req"}, req_valid, exp_req);
  endtask

  initial begin
    rst_n = 1'b0;
    rd = '0;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    resp_hit = 1'b0;
    resp_value = '0;
    step();
    step();
    chk("rst_wr", reg_wr, '0);
    chk("rst_outs", {req_valid, core_op, core_key, core_value, timeout, idle},
        {1'b0, 3'd0, 16'd0, 32'd0, 1'b0, 1'b1});
    rst_n = 1'b1;
    step();
    chk("idle_hold", {idle, reg_wr != '0}, 2'b10);

    // WRITE, response 2 cycles after handshake
    rd.dat = 32'hCAFE; rd.key = 16'h11; rd.operation = OP_WRITE; req_ready = 1'b1;
    step();
    chk_busy("wr_issue", 1'b1);
    chk("wr_payload", {core_op, core_key, core_value}, {3'd2, 16'h11, 32'hCAFE});
    step();
    chk("wr_wait", {req_valid, wr.busy_valid, idle}, 3'b000);
    step();
    resp_valid = 1'b1; resp_hit = 1'b1;
    step();
    chk_done("wr_done", 1'b1, 1'b0, '0, 1'b0);
    resp_valid = 1'b0; rd.operation = OP_NOOP; req_ready = 1'b0;
    step();
    chk("wr_back_idle", {idle, wr.hit_valid, wr.busy_valid}, 3'b100);

    // READ hit, response in the same cycle as the handshake
    rd.operation = OP_READ; rd.key = 16'h11;
    step();
    chk_busy("rdh_issue", 1'b1);
    req_ready = 1'b1; resp_valid = 1'b1; resp_hit = 1'b1; resp_value = 32'hCAFE;
    step();
    chk_done("rdh_done", 1'b1, 1'b1, 32'hCAFE, 1'b0);
    resp_valid = 1'b0; rd.operation = OP_NOOP; req_ready = 1'b0;
    step();
    chk("rdh_idle", idle, 1'b1);

    // READ miss with 5 cycles of backpressure and a spurious early response
    rd.operation = OP_READ; rd.key = 16'h33;
    step();
    chk_busy("rdm_issue", 1'b1);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("rdm_hold%0d", i), {req_valid, core_op, core_key}, {1'b1, 3'd1, 16'h33});
      resp_valid = (i == 3); resp_hit = 1'b1; resp_value = 32'hDEAD;
      step();
    end
    chk("rdm_hold6", {req_valid, core_op, core_key, idle}, {1'b1, 3'd1, 16'h33, 1'b0});
    resp_valid = 1'b0; req_ready = 1'b1;
    step();
    chk("rdm_wait", req_valid, 1'b0);
    req_ready = 1'b0; resp_valid = 1'b1; resp_hit = 1'b0; resp_value = 32'h1234;
    step();
    chk_done("rdm_done", 1'b0, 1'b0, '0, 1'b0);
    resp_valid = 1'b0; rd.operation = OP_NOOP;
    step();
    chk("rdm_idle", idle, 1'b1);

    // DELETE with no response: timeout after 16 cycles
    rd.operation = OP_DELETE; rd.key = 16'h44; req_ready = 1'b1;
    step();
    chk_busy("tmo_issue", 1'b1);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("tmo_wait%0d", i), {timeout, idle, wr.hit_valid}, 3'b000);
    end
    step();
    chk_done("tmo_done", 1'b0, 1'b0, '0, 1'b1);
    rd.operation = OP_NOOP; req_ready = 1'b0;
    step();
    chk("tmo_after", {timeout, idle}, 2'b01);

    // Next command after timeout is accepted normally
    rd.operation = OP_WRITE; rd.key = 16'h55; rd.dat = 32'h77; req_ready = 1'b1;
    step();
    chk_busy("nxt_issue", 1'b1);
    chk("nxt_payload", {core_op, core_key, core_value}, {3'd2, 16'h55, 32'h77});
    step();
    resp_valid = 1'b1; resp_hit = 1'b1;
    step();
    chk_done("nxt_done", 1'b1, 1'b0, '0, 1'b0);
    resp_valid = 1'b0; rd.operation = OP_NOOP; req_ready = 1'b0;
    step();

    // Unsupported op 5
    rd.operation = operation_e'(3'd5);
    step();
    chk_busy("uns_issue", 1'b0);
    step();
    chk_done("uns_done", 1'b0, 1'b0, '0, 1'b0);
    rd.operation = OP_NOOP;
    step();
    chk("uns_idle", {idle, req_valid}, 2'b10);

    // Register change while busy, then reset mid-WAIT
    rd.operation = OP_WRITE; rd.key = 16'h22; rd.dat = 32'h1; req_ready = 1'b1;
    step();
    step();
    chk("rst_wait", {req_valid, idle}, 2'b00);
    rd.key = 16'h99; req_ready = 1'b0;
    step();
    chk("key_stable", core_key, 16'h22);
    rst_n = 1'b0;
    step();
    chk("midrst_wr", reg_wr, '0);
    chk("midrst_outs", {req_valid, core_op, core_key, core_value, timeout, idle},
        {1'b0, 3'd0, 16'd0, 32'd0, 1'b0, 1'b1});
    rst_n = 1'b1; rd.operation = OP_NOOP; resp_valid = 1'b1; resp_hit = 1'b1;
    step();
    chk("postrst_idle", {idle, reg_wr != '0, req_valid}, 3'b100);
    resp_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
